// File: rtl/alu_issue_pkg.sv
// Shared constants, state encoding and RV32 instruction field helpers for the ALU issue unit.
package alu_issue_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  function automatic logic [6:0] get_opcode(input logic [31:0] instr);
    return instr[6:0];
  endfunction

  function automatic logic [4:0] get_rd(input logic [31:0] instr);
    return instr[11:7];
  endfunction

  function automatic logic [2:0] get_funct3(input logic [31:0] instr);
    return instr[14:12];
  endfunction

  function automatic logic [4:0] get_rs1(input logic [31:0] instr);
    return instr[19:15];
  endfunction

  function automatic logic [4:0] get_rs2(input logic [31:0] instr);
    return instr[24:20];
  endfunction

  function automatic logic [6:0] get_funct7(input logic [31:0] instr);
    return instr[31:25];
  endfunction

  function automatic logic [31:0] get_imm_i(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  // Only SRAI carries a meaningful upper-immediate selector; every other I-type op is funct7 = 0.
  function automatic logic [6:0] get_i_funct7(input logic [31:0] instr);
    logic [6:0] f7;
    if ((instr[14:12] == F3_SR) && (instr[31:25] == F7_ALT)) begin
      f7 = F7_ALT;
    end else begin
      f7 = F7_BASE;
    end
    return f7;
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Bundle of the fetch, ALU, result and debug signals of the ALU issue unit.
interface alu_issue_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] alu_in0;
  logic [31:0] alu_in1;
  logic [9:0]  alu_sel;
  logic [31:0] alu_out;
  logic        alu_zero;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_zero;
  logic [4:0]  res_rd;
  logic        res_illegal;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  modport master (
    input  in_valid, in_instr, alu_out, alu_zero, res_ready, dbg_addr,
    output in_ready, alu_in0, alu_in1, alu_sel, res_valid, res_data, res_zero, res_rd,
           res_illegal, dbg_data
  );

  modport slave (
    output in_valid, in_instr, alu_out, alu_zero, res_ready, dbg_addr,
    input  in_ready, alu_in0, alu_in1, alu_sel, res_valid, res_data, res_zero, res_rd,
           res_illegal, dbg_data
  );

endinterface

// File: rtl/alu_issue_regfile.sv
// NREGS x 32 register file: two operand reads plus a debug read, one write port, x0 reads as zero.
module alu_issue_regfile #(
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rd_addr0,
  input  logic [AW-1:0] rd_addr1,
  input  logic [AW-1:0] dbg_addr,
  output logic [31:0]   rd_data0,
  output logic [31:0]   rd_data1,
  output logic [31:0]   dbg_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data
);

  logic [31:0] mem_r [NREGS];

  // Storage: whole-array clear on reset, single write port that never touches x0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_r[i] <= 32'd0;
      end
    end else if (wr_en && (wr_addr != {AW{1'b0}})) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data0 = (rd_addr0 == {AW{1'b0}}) ? 32'd0 : mem_r[rd_addr0];
  assign rd_data1 = (rd_addr1 == {AW{1'b0}}) ? 32'd0 : mem_r[rd_addr1];
  assign dbg_data = (dbg_addr == {AW{1'b0}}) ? 32'd0 : mem_r[dbg_addr];

endmodule

// File: rtl/alu_issue_unit.sv
// Single-issue RV32 R/I-type ALU sequencer: IDLE -> READ -> EXEC -> WB with an internal register file.
// Define ALU_ISSUE_SKID_EN to add a one-entry instruction skid buffer (accept while busy).
module alu_issue_unit
  import alu_issue_pkg::*;
#(
  parameter int NREGS = 32
) (
  input logic         clk,
  input logic         rst,
  alu_issue_if.master bus
);

  localparam int REG_AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  state_t      state_r;
  logic [31:0] instr_r;
  logic [31:0] alu_in0_r;
  logic [31:0] alu_in1_r;
  logic [9:0]  alu_sel_r;
  logic        illegal_r;
  logic        in_ready_r;
  logic        res_valid_r;
  logic [31:0] res_data_r;
  logic        res_zero_r;
  logic [4:0]  res_rd_r;
  logic        res_illegal_r;

`ifdef ALU_ISSUE_SKID_EN
  logic        skid_valid_r;
  logic [31:0] skid_instr_r;
`endif

  logic [4:0]        rs1_full_s;
  logic [4:0]        rs2_full_s;
  logic [4:0]        rd_full_s;
  logic [REG_AW-1:0] rs1_s;
  logic [REG_AW-1:0] rs2_s;
  logic [REG_AW-1:0] rd_s;
  logic [31:0]       rs1_val_s;
  logic [31:0]       rs2_val_s;
  logic [31:0]       dec_in0_s;
  logic [31:0]       dec_in1_s;
  logic [9:0]        dec_sel_s;
  logic              dec_illegal_s;
  logic              accept_s;
  logic              res_fire_s;
  logic              wr_en_s;

  assign rs1_full_s = get_rs1(instr_r);
  assign rs2_full_s = get_rs2(instr_r);
  assign rd_full_s  = get_rd(instr_r);
  assign rs1_s      = rs1_full_s[REG_AW-1:0];
  assign rs2_s      = rs2_full_s[REG_AW-1:0];
  assign rd_s       = rd_full_s[REG_AW-1:0];

  assign accept_s   = bus.in_valid && in_ready_r;
  assign res_fire_s = (state_r == ST_WB) && res_valid_r && bus.res_ready;
  assign wr_en_s    = res_fire_s && !res_illegal_r && (res_rd_r != 5'd0);

  alu_issue_regfile #(
    .NREGS (NREGS),
    .AW    (REG_AW)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .rd_addr0 (rs1_s),
    .rd_addr1 (rs2_s),
    .dbg_addr (bus.dbg_addr[REG_AW-1:0]),
    .rd_data0 (rs1_val_s),
    .rd_data1 (rs2_val_s),
    .dbg_data (bus.dbg_data),
    .wr_en    (wr_en_s),
    .wr_addr  (res_rd_r[REG_AW-1:0]),
    .wr_data  (res_data_r)
  );

  // Decode the latched instruction into ALU operands and selector; unknown opcodes drive zeros.
  always_comb begin
    dec_in0_s     = 32'd0;
    dec_in1_s     = 32'd0;
    dec_sel_s     = 10'd0;
    dec_illegal_s = 1'b1;
    case (get_opcode(instr_r))
      OP_R: begin
        dec_in0_s     = rs1_val_s;
        dec_in1_s     = rs2_val_s;
        dec_sel_s     = {get_funct7(instr_r), get_funct3(instr_r)};
        dec_illegal_s = 1'b0;
      end
      OP_I: begin
        dec_in0_s     = rs1_val_s;
        dec_in1_s     = get_imm_i(instr_r);
        dec_sel_s     = {get_i_funct7(instr_r), get_funct3(instr_r)};
        dec_illegal_s = 1'b0;
      end
      default: begin
        dec_illegal_s = 1'b1;
      end
    endcase
  end

  // Sequencer: state, ALU drive registers, result registers and the input handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      instr_r       <= 32'd0;
      alu_in0_r     <= 32'd0;
      alu_in1_r     <= 32'd0;
      alu_sel_r     <= 10'd0;
      illegal_r     <= 1'b0;
      in_ready_r    <= 1'b1;
      res_valid_r   <= 1'b0;
      res_data_r    <= 32'd0;
      res_zero_r    <= 1'b0;
      res_rd_r      <= 5'd0;
      res_illegal_r <= 1'b0;
`ifdef ALU_ISSUE_SKID_EN
      skid_valid_r  <= 1'b0;
      skid_instr_r  <= 32'd0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            instr_r <= bus.in_instr;
            state_r <= ST_READ;
`ifndef ALU_ISSUE_SKID_EN
            in_ready_r <= 1'b0;
`endif
          end
        end
        ST_READ: begin
          alu_in0_r <= dec_in0_s;
          alu_in1_r <= dec_in1_s;
          alu_sel_r <= dec_sel_s;
          illegal_r <= dec_illegal_s;
          state_r   <= ST_EXEC;
        end
        ST_EXEC: begin
          res_data_r    <= illegal_r ? 32'd0 : bus.alu_out;
          res_zero_r    <= illegal_r ? 1'b0 : bus.alu_zero;
          res_rd_r      <= 5'(rd_s);
          res_illegal_r <= illegal_r;
          state_r       <= ST_WB;
        end
        ST_WB: begin
          // First WB cycle only raises res_valid; the handshake can complete from the next cycle.
          if (!res_valid_r) begin
            res_valid_r <= 1'b1;
          end else if (bus.res_ready) begin
            res_valid_r <= 1'b0;
`ifdef ALU_ISSUE_SKID_EN
            if (skid_valid_r) begin
              instr_r      <= skid_instr_r;
              skid_valid_r <= 1'b0;
              in_ready_r   <= 1'b1;
              state_r      <= ST_READ;
            end else if (accept_s) begin
              instr_r <= bus.in_instr;
              state_r <= ST_READ;
            end else begin
              state_r <= ST_IDLE;
            end
`else
            in_ready_r <= 1'b1;
            state_r    <= ST_IDLE;
`endif
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
`ifdef ALU_ISSUE_SKID_EN
      if (accept_s && (state_r != ST_IDLE) && !res_fire_s) begin
        skid_valid_r <= 1'b1;
        skid_instr_r <= bus.in_instr;
        in_ready_r   <= 1'b0;
      end
`endif
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.alu_in0     = alu_in0_r;
  assign bus.alu_in1     = alu_in1_r;
  assign bus.alu_sel     = alu_sel_r;
  assign bus.res_valid   = res_valid_r;
  assign bus.res_data    = res_data_r;
  assign bus.res_zero    = res_zero_r;
  assign bus.res_rd      = res_rd_r;
  assign bus.res_illegal = res_illegal_r;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a behavioural RV32 ALU closing the loop.
module tb_alu_issue_unit;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_acc = 0;
  int   n_hs = 0;

  alu_issue_if bus ();

  alu_issue_unit #(.NREGS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU responding combinationally to the unit's selector.
  always_comb begin
    case (bus.alu_sel)
      10'h000: bus.alu_out = bus.alu_in0 + bus.alu_in1;
      10'h100: bus.alu_out = bus.alu_in0 - bus.alu_in1;
      10'h001: bus.alu_out = bus.alu_in0 << bus.alu_in1[4:0];
      10'h002: bus.alu_out = {31'd0, $signed(bus.alu_in0) < $signed(bus.alu_in1)};
      10'h003: bus.alu_out = {31'd0, bus.alu_in0 < bus.alu_in1};
      10'h004: bus.alu_out = bus.alu_in0 ^ bus.alu_in1;
      10'h005: bus.alu_out = bus.alu_in0 >> bus.alu_in1[4:0];
      10'h105: bus.alu_out = $signed(bus.alu_in0) >>> bus.alu_in1[4:0];
      10'h006: bus.alu_out = bus.alu_in0 | bus.alu_in1;
      10'h007: bus.alu_out = bus.alu_in0 & bus.alu_in1;
      default: bus.alu_out = 32'd0;
    endcase
    bus.alu_zero = (bus.alu_out == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input string tag, input logic [31:0] instr);
    bus.in_instr = instr;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 20 && !bus.in_ready; k++) @(negedge clk);
    check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    n_acc = cyc;
  endtask

  task automatic wait_res(input string tag, input int base, input int lat);
    for (int k = 0; k < 20 && !bus.res_valid; k++) @(negedge clk);
    check({tag, "_valid"}, {31'd0, bus.res_valid}, 32'd1);
    check({tag, "_lat"}, 32'(cyc - base), 32'(lat));
  endtask

  task automatic take_res();
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    n_hs = cyc;
  endtask

  task automatic run(input string tag, input logic [31:0] instr, input logic [31:0] data,
                     input logic zero, input logic [4:0] rd);
    issue(tag, instr);
    wait_res(tag, n_acc, 3);
    check({tag, "_data"}, bus.res_data, data);
    check({tag, "_zero"}, {31'd0, bus.res_zero}, {31'd0, zero});
    check({tag, "_rd"}, {27'd0, bus.res_rd}, {27'd0, rd});
    check({tag, "_illegal"}, {31'd0, bus.res_illegal}, 32'd0);
    take_res();
  endtask

  task automatic dbg(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    bus.dbg_addr = addr;
    #1;
    check(tag, bus.dbg_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_instr  = 32'd0;
    bus.res_ready = 1'b0;
    bus.dbg_addr  = 5'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    check("rst_alu_sel", {22'd0, bus.alu_sel}, 32'd0);
    check("rst_alu_in0", bus.alu_in0, 32'd0);
    check("rst_res_data", bus.res_data, 32'd0);
    dbg("rst_dbg_x1", 5'd1, 32'd0);

    run("addi_x1", 32'h00500093, 32'd5, 1'b0, 5'd1);
    check("addi_sel", {22'd0, bus.alu_sel}, 32'd0);
    check("addi_in1", bus.alu_in1, 32'd5);
    dbg("dbg_x1", 5'd1, 32'd5);

    run("addi_x2", 32'h00500113, 32'd5, 1'b0, 5'd2);
    run("add_x3", 32'h002081B3, 32'd10, 1'b0, 5'd3);
    dbg("dbg_x3", 5'd3, 32'd10);

    run("sub_x4", 32'h40208233, 32'd0, 1'b1, 5'd4);
    check("sub_sel", {22'd0, bus.alu_sel}, 32'h100);

    run("slli_x5", 32'h00109293, 32'd10, 1'b0, 5'd5);
    check("slli_sel", {22'd0, bus.alu_sel}, 32'h001);

    run("addi_x0", 32'h00700013, 32'd7, 1'b0, 5'd0);
    dbg("dbg_x0", 5'd0, 32'd0);

    run("addi_neg", 32'hFF800513, 32'hFFFFFFF8, 1'b0, 5'd10);
    run("srai_x11", 32'h40155593, 32'hFFFFFFFC, 1'b0, 5'd11);
    check("srai_sel", {22'd0, bus.alu_sel}, 32'h105);
    dbg("dbg_x11", 5'd11, 32'hFFFFFFFC);

    issue("illegal", 32'hFFFFFFFF);
    wait_res("illegal", n_acc, 3);
    for (int k = 0; k < 5; k++) begin
      check("ill_valid_hold", {31'd0, bus.res_valid}, 32'd1);
      check("ill_flag", {31'd0, bus.res_illegal}, 32'd1);
      check("ill_data", bus.res_data, 32'd0);
      check("ill_zero", {31'd0, bus.res_zero}, 32'd0);
      @(negedge clk);
    end
    check("ill_alu_sel", {22'd0, bus.alu_sel}, 32'd0);
    take_res();
    check("ill_valid_drop", {31'd0, bus.res_valid}, 32'd0);
    dbg("ill_dbg_x31", 5'd31, 32'd0);
    dbg("ill_dbg_x1", 5'd1, 32'd5);

`ifdef ALU_ISSUE_SKID_EN
    issue("skid_a", 32'h00300393);
    bus.in_instr = 32'h00400413;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("skid_full", {31'd0, bus.in_ready}, 32'd0);
    wait_res("skid_a", n_acc, 3);
    check("skid_a_data", bus.res_data, 32'd3);
    take_res();
    wait_res("skid_b", n_hs, 3);
    check("skid_b_data", bus.res_data, 32'd4);
    check("skid_b_rd", {27'd0, bus.res_rd}, 32'd8);
    take_res();
    dbg("skid_dbg_x8", 5'd8, 32'd4);
`endif

    issue("rst_exec", 32'h00900313);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("abort_res_valid", {31'd0, bus.res_valid}, 32'd0);
    dbg("abort_dbg_x6", 5'd6, 32'd0);
    dbg("abort_dbg_x1", 5'd1, 32'd0);
    repeat (4) @(negedge clk);
    check("abort_quiet", {31'd0, bus.res_valid}, 32'd0);

    run("post_rst", 32'h00500093, 32'd5, 1'b0, 5'd1);
    dbg("post_dbg_x1", 5'd1, 32'd5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
